// File: rtl/keyboard_matrix.sv
// Keyboard matrix: the Pi writes rows, and the CPU selects a row via PIA1 PORTA and reads it via PORTB.
// Optional build macro KEYBOARD_MATRIX_STALE_CLEAR_EN releases all keys after STALE_TICKS idle cycles.
module keyboard_matrix #(
  parameter int          NUM_ROWS    = 10,
  parameter int          NUM_COLS    = 8,
  parameter logic [15:0] BASE_ADDR   = 16'hE800,
  parameter logic [23:0] STALE_TICKS = 24'd1_600_000
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [15:0]         pi_addr,
  input  logic [7:0]          pi_data,
  input  logic                pi_wr_strobe,
  input  logic [1:0]          bus_addr,
  input  logic [7:0]          bus_data_in,
  input  logic                pia1_enabled_in,
  input  logic                io_read,
  input  logic                cpu_write,
  output logic [NUM_COLS-1:0] kbd_data_out,
  output logic                kbd_enable,
  output logic                any_key
);

  localparam logic [NUM_COLS-1:0] ONES     = {NUM_COLS{1'b1}};
  localparam logic [15:0]         ROWS_W16 = 16'(NUM_ROWS);

  logic [1:0]          rst_sync_r;
  logic                rst_n_s;
  logic [NUM_COLS-1:0] matrix_r [NUM_ROWS];
  logic [NUM_COLS-1:0] kbd_data_r;
  logic [NUM_COLS-1:0] sel_row_s;
  logic [15:0]         pi_off_s;
  logic [3:0]          pi_row_s;
  logic                pi_hit_s;
  logic                wr_porta_s, wr_porta_r;
  logic                rd_portb_s, rd_portb_r;
  logic                rd_rise_s, wr_fall_s;
  logic [3:0]          row_sel_r;
  logic                and_all_s;
  logic                any_key_r;
  logic                stale_clr_s;
  logic                unused_s;

  // Reset synchronizer: asserts immediately, releases on the second clk edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) rst_sync_r <= 2'b00;
    else          rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  assign pi_off_s   = pi_addr - BASE_ADDR;
  assign pi_row_s   = pi_off_s[3:0];
  assign pi_hit_s   = pi_wr_strobe && (pi_addr >= BASE_ADDR) && (pi_off_s < ROWS_W16);
  assign wr_porta_s = cpu_write & pia1_enabled_in & (bus_addr == 2'd0);
  assign rd_portb_s = io_read & pia1_enabled_in & (bus_addr == 2'd2);
  assign wr_fall_s  = wr_porta_r & ~wr_porta_s;
  assign rd_rise_s  = rd_portb_s & ~rd_portb_r;
  assign unused_s   = ^bus_data_in[7:4];

`ifdef KEYBOARD_MATRIX_STALE_CLEAR_EN
  localparam logic [23:0] STALE_MAX = STALE_TICKS - 24'd1;
  logic [23:0] stale_cnt_r;

  // Saturating idle counter, restarted by every in-window Pi write.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s)                    stale_cnt_r <= 24'd0;
    else if (pi_hit_s)               stale_cnt_r <= 24'd0;
    else if (stale_cnt_r != STALE_MAX) stale_cnt_r <= stale_cnt_r + 24'd1;
  end
  assign stale_clr_s = (stale_cnt_r == STALE_MAX);
`else
  assign stale_clr_s = 1'b0;
`endif

  // Matrix rows; a Pi write to a row takes priority over the stale clear.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      for (int r = 0; r < NUM_ROWS; r++) matrix_r[r] <= ONES;
    end else begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (pi_hit_s && (pi_row_s == 4'(r))) matrix_r[r] <= pi_data[NUM_COLS-1:0];
        else if (stale_clr_s)                matrix_r[r] <= ONES;
      end
    end
  end

  // Row mux; selects beyond the matrix read as released keys.
  always_comb begin
    sel_row_s = ONES;
    and_all_s = 1'b1;
    for (int r = 0; r < NUM_ROWS; r++) begin
      sel_row_s = (row_sel_r == 4'(r)) ? matrix_r[r] : sel_row_s;
      and_all_s = and_all_s & (&matrix_r[r]);
    end
  end

  // Bus edge detectors, row select, PORTB capture and key-down flag.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      wr_porta_r <= 1'b1;
      rd_portb_r <= 1'b1;
      row_sel_r  <= 4'd0;
      kbd_data_r <= ONES;
      any_key_r  <= 1'b0;
    end else begin
      wr_porta_r <= wr_porta_s;
      rd_portb_r <= rd_portb_s;
      any_key_r  <= ~and_all_s;
      if (wr_fall_s) row_sel_r  <= bus_data_in[3:0];
      if (rd_rise_s) kbd_data_r <= sel_row_s;
    end
  end

  assign kbd_data_out = kbd_data_r;
  assign any_key      = any_key_r;
  // With nothing pressed the read falls through to PIA1.
  assign kbd_enable   = rd_portb_s & (kbd_data_r != ONES);

endmodule

// File: tb/tb_keyboard_matrix.sv
// Self-checking bench for keyboard_matrix: expected PORTB results are queued at stimulus time and popped on capture.
// Stale-clear expectations follow KEYBOARD_MATRIX_STALE_CLEAR_EN.
module tb_keyboard_matrix;

  logic        clk;
  logic        reset_b;
  logic [15:0] pi_addr;
  logic [7:0]  pi_data;
  logic        pi_wr_strobe;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_data_in;
  logic        pia1_enabled_in;
  logic        io_read;
  logic        cpu_write;
  logic [7:0]  kbd_data_out;
  logic        kbd_enable;
  logic        any_key;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q [$];

  keyboard_matrix #(
    .NUM_ROWS(10), .NUM_COLS(8), .BASE_ADDR(16'hE800), .STALE_TICKS(24'd16)
  ) dut (
    .clk(clk), .reset_b(reset_b), .pi_addr(pi_addr), .pi_data(pi_data),
    .pi_wr_strobe(pi_wr_strobe), .bus_addr(bus_addr), .bus_data_in(bus_data_in),
    .pia1_enabled_in(pia1_enabled_in), .io_read(io_read), .cpu_write(cpu_write),
    .kbd_data_out(kbd_data_out), .kbd_enable(kbd_enable), .any_key(any_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pi_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pi_addr = a; pi_data = d; pi_wr_strobe = 1'b1;
    @(negedge clk);
    pi_wr_strobe = 1'b0;
  endtask

  task automatic porta_write(input logic [7:0] v);
    @(negedge clk);
    bus_addr = 2'd0; bus_data_in = v; cpu_write = 1'b1;
    @(negedge clk);
    cpu_write = 1'b0;
    @(negedge clk);
  endtask

  // One PORTB read: result is due one edge after io_read is first sampled.
  task automatic portb_read(input string name, input logic [7:0] exp_d, input logic exp_en);
    logic [8:0] e;
    @(negedge clk);
    bus_addr = 2'd2; io_read = 1'b1;
    exp_q.push_back({exp_en, exp_d});
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if ({kbd_enable, kbd_data_out} !== e) begin
        n_fail++;
        $display("FAIL %s: got en=%b data=%h, expected en=%b data=%h",
                 name, kbd_enable, kbd_data_out, e[8], e[7:0]);
      end
    end
    io_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({kbd_data_out, kbd_enable, any_key} !== {8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h en=%b any=%b, expected data=ff en=0 any=0",
               kbd_data_out, kbd_enable, any_key);
    end
    reset_b = 1'b1;
    repeat (4) @(negedge clk);
    portb_read("reset_row0", 8'hFF, 1'b0);
  endtask

  task automatic test_window;
    pi_write(16'hE7FF, 8'h00);
    pi_write(16'hE80A, 8'h00);
    for (int r = 0; r < 10; r++) begin
      porta_write(8'(r));
      portb_read($sformatf("window_row%0d", r), 8'hFF, 1'b0);
    end
    porta_write(8'h0C);
    portb_read("row_sel_12", 8'hFF, 1'b0);
    n_checks++;
    if (any_key !== 1'b0) begin
      n_fail++;
      $display("FAIL window_any_key: got %b, expected 0", any_key);
    end
  endtask

  task automatic test_main;
    pi_write(16'hE803, 8'hFB);
    porta_write(8'h03);
    portb_read("row3_fb", 8'hFB, 1'b1);
    n_checks++;
    if (any_key !== 1'b1) begin
      n_fail++;
      $display("FAIL main_any_key: got %b, expected 1", any_key);
    end
    pi_write(16'hE809, 8'hFE);
    porta_write(8'h09);
    portb_read("row9_last", 8'hFE, 1'b1);
    pi_write(16'hE800, 8'h7E);
    porta_write(8'hF0);
    portb_read("row0_first", 8'h7E, 1'b1);
  endtask

  task automatic test_back_to_back;
    pi_write(16'hE805, 8'hAA);
    porta_write(8'h05);
    @(negedge clk);
    bus_addr = 2'd2; io_read = 1'b1;
    pi_addr = 16'hE805; pi_data = 8'h55; pi_wr_strobe = 1'b1;
    exp_q.push_back({1'b1, 8'hAA});
    @(negedge clk);
    pi_wr_strobe = 1'b0;
    n_checks++;
    if ({kbd_enable, kbd_data_out} !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL collide_old: got en=%b data=%h, expected en=1 data=aa", kbd_enable, kbd_data_out);
    end
    io_read = 1'b0;
    @(negedge clk);
    portb_read("collide_new", 8'h55, 1'b1);
  endtask

  task automatic test_stale;
    pi_write(16'hE802, 8'h7F);
    repeat (20) @(negedge clk);
    porta_write(8'h02);
`ifdef KEYBOARD_MATRIX_STALE_CLEAR_EN
    portb_read("stale_row2", 8'hFF, 1'b0);
    n_checks++;
    if (any_key !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_any_key: got %b, expected 0", any_key);
    end
`else
    portb_read("stale_row2", 8'h7F, 1'b1);
    n_checks++;
    if (any_key !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_any_key: got %b, expected 1", any_key);
    end
`endif
  endtask

  task automatic test_reset_mid_read;
    pi_write(16'hE803, 8'h00);
    porta_write(8'h03);
    @(negedge clk);
    bus_addr = 2'd2; io_read = 1'b1;
    #2 reset_b = 1'b0;
    #1;
    n_checks++;
    if ({kbd_data_out, kbd_enable, any_key} !== {8'hFF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_read: got data=%h en=%b any=%b, expected data=ff en=0 any=0",
               kbd_data_out, kbd_enable, any_key);
    end
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (kbd_data_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_no_capture: got %h, expected ff", kbd_data_out);
    end
    io_read = 1'b0;
    @(negedge clk);
    portb_read("first_read_after_reset", 8'hFF, 1'b0);
  endtask

  initial begin
    reset_b = 1'b0; pi_addr = 16'h0000; pi_data = 8'h00; pi_wr_strobe = 1'b0;
    bus_addr = 2'd0; bus_data_in = 8'h00; pia1_enabled_in = 1'b1;
    io_read = 1'b0; cpu_write = 1'b0;
    test_reset();
    test_window();
    test_main();
    test_back_to_back();
    test_stale();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keyboard_matrix.md
KEYBOARD_MATRIX -- requirements
Module: keyboard_matrix

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 10, meaning the number of matrix rows (1..16).
REQ-002 SHALL have parameter NUM_COLS, default 8, meaning the row width in bits (1..8).
REQ-003 SHALL have parameter BASE_ADDR, default 16'hE800, meaning the Pi address of row 0.
REQ-004 SHALL have parameter STALE_TICKS, default 24'd1_600_000, meaning idle cycles before the matrix auto-clears.
REQ-005 SHALL have port clk, input, 1, the single system clock; all state is clocked on its rising edge.
REQ-006 SHALL have port reset_b, input, 1, the asynchronous active-low reset.
REQ-007 SHALL have port pi_addr, input, 16, the Pi write address.
REQ-008 SHALL have port pi_data, input, 8, the Pi write data; bits above NUM_COLS-1 are ignored.
REQ-009 SHALL have port pi_wr_strobe, input, 1, a one-cycle Pi write strobe.
REQ-010 SHALL have port bus_addr, input, 2, the PIA register select (0=PORTA, 1=CRA, 2=PORTB, 3=CRB).
REQ-011 SHALL have port bus_data_in, input, 8, the CPU write data.
REQ-012 SHALL have port pia1_enabled_in, input, 1, asserted while PIA1 is selected.
REQ-013 SHALL have port io_read, input, 1, a CPU read-cycle level.
REQ-014 SHALL have port cpu_write, input, 1, a CPU write-cycle level.
REQ-015 SHALL have port kbd_data_out, output, NUM_COLS, the registered column data for the selected row.
REQ-016 SHALL have port kbd_enable, output, 1, asserted when this block drives the PORTB read.
REQ-017 SHALL have port any_key, output, 1, asserted when any matrix bit is 0.

Function
REQ-018 Matrix SHALL be NUM_ROWS x NUM_COLS, active-low (0 = pressed).
REQ-019 When pi_wr_strobe=1 and BASE_ADDR <= pi_addr < BASE_ADDR+NUM_ROWS, row (pi_addr-BASE_ADDR) SHALL load pi_data[NUM_COLS-1:0] on that edge; out-of-window writes SHALL be ignored.
REQ-020 wr_porta = cpu_write & pia1_enabled_in & (bus_addr==0); on its registered falling edge, row_sel SHALL load bus_data_in[3:0].
REQ-021 rd_portb = io_read & pia1_enabled_in & (bus_addr==2); on its registered rising edge, kbd_data_out SHALL load matrix[row_sel], with one-cycle latency.
REQ-022 row_sel >= NUM_ROWS SHALL yield all-ones on kbd_data_out.
REQ-023 kbd_enable SHALL equal rd_portb & (kbd_data_out != all-ones), so the reads fall through to PIA1 when no key is pressed.
REQ-024 On a simultaneous Pi write to row R and PORTB capture of row R, kbd_data_out SHALL take the old row value; the new value SHALL be visible on the next read.
REQ-025 any_key SHALL be registered and SHALL be the AND-reduce of all matrix bits, inverted.

Reset
REQ-026 When reset_b=0, all matrix rows, kbd_data_out, and the edge-detect registers SHALL be all-ones; row_sel, the stale counter, and any_key SHALL be 0; and kbd_enable SHALL be 0.
REQ-027 Reset SHALL take effect asynchronously and SHALL release synchronously to clk.
REQ-028 Reset asserted mid-read SHALL abort the capture; the first read after reset SHALL return all-ones.

Configuration
REQ-029 Macro KEYBOARD_MATRIX_STALE_CLEAR_EN SHALL gate the stale-clear feature.
REQ-030 With the macro defined, a saturating counter SHALL increment each cycle and clear on any in-window Pi write.
REQ-031 With the macro defined, when the counter reaches STALE_TICKS-1, all rows SHALL be set to all-ones on the next edge; the counter SHALL hold at STALE_TICKS-1 until the next in-window Pi write.
REQ-032 With the macro defined, an in-window Pi write in the same cycle as the clear SHALL win for its row, and the counter SHALL restart at 0.
REQ-033 Without the macro, the counter SHALL be absent and the matrix SHALL retain its contents indefinitely.

Verification
REQ-034 Reset, then PORTB read with row_sel=0 -> kbd_data_out=8'hFF and kbd_enable=0.
REQ-035 Pi write $E803=8'hFB, CPU write PORTA=8'h03, then PORTB read -> kbd_data_out=8'hFB one cycle after the read edge, kbd_enable=1, any_key=1.
REQ-036 Pi writes $E7FF and $E80A (NUM_ROWS=10), then read rows 0-9 -> all return 8'hFF; PORTA=8'h0C -> 8'hFF.
REQ-037 Pi write to row 5 on the same edge as a row-5 PORTB capture -> first read returns the old value, second read returns the new value.
REQ-038 With the macro defined and STALE_TICKS=16, Pi write row 2=8'h7F then 16 idle cycles -> row 2 reads 8'hFF and any_key=0; without the macro -> row 2 still reads 8'h7F.
REQ-039 Assert reset_b mid PORTB read with row 3=8'h00 -> kbd_data_out=8'hFF immediately and kbd_enable=0.
